// File: rtl/cpu_types_pkg.sv
// Shared types for the memory-stage access controller.
// Word type, memory-access FSM states and the default miss timeout.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HALT
    } memstate_t;

    localparam int unsigned TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/ll_sc_link.sv
// LL/SC link register with coherence invalidation.
// Reports whether a store-conditional presented this cycle must fail.
module ll_sc_link
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  sc_i,
    input  word_t addr_i,
    input  logic  ll_hit_i,
    input  logic  st_hit_i,
    input  logic  ccinv_i,
    input  word_t ccsnoopaddr_i,
    output logic  sc_fail_o
);

    logic  link_valid_q, link_valid_d;
    word_t link_addr_q, link_addr_d;
    logic  snoop_hits_addr;
    logic  snoop_hits_link;

    assign snoop_hits_addr = ccinv_i & (ccsnoopaddr_i == addr_i);
    assign snoop_hits_link = ccinv_i & (ccsnoopaddr_i == link_addr_q);

    always_comb begin
        // NOTE: defaults first so every path assigns the next state; a missing branch would infer a latch.
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (ll_hit_i) begin
            // An invalidate of the freshly linked word in the same cycle wins.
            link_addr_d  = addr_i;
            link_valid_d = ~snoop_hits_addr;
        end else if (st_hit_i || snoop_hits_link) begin
            link_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!nRST) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    assign sc_fail_o = sc_i & (~link_valid_q | (link_addr_q != addr_i) | snoop_hits_addr);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues cache requests, holds the pipeline until dhit,
// runs LL/SC and the halt/timeout status, and selects the word latched into MEM/WB.
module mem_access_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  valid_i,
    input  logic  memren_i,
    input  logic  memwen_i,
    input  logic  ll_i,
    input  logic  sc_i,
    input  logic  halt_i,
    input  word_t addr_i,
    input  word_t store_i,
    input  logic  dhit,
    input  word_t dmemload,
    input  logic  ccinv,
    input  word_t ccsnoopaddr,
    output logic  dmemREN,
    output logic  dmemWEN,
    output word_t dmemaddr,
    output word_t dmemstore,
    output word_t rdata_o,
    output logic  stall_o,
    output logic  memwb_en_o,
    output logic  memwb_flush_o,
    output logic  halted_o,
    output logic  err_o
);

    localparam int unsigned      CNT_W      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT);
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

    memstate_t        state_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             err_q;

    logic in_service;
    logic memop;
    logic sc_fail_raw;
    logic sc_fail;
    logic req;
    logic miss;
    logic halt_go;

    // Reset is folded in so requests drop the moment nRST falls, not at the next edge.
    assign in_service = nRST & (state_q != HALT);
    assign memop      = valid_i & (memren_i | memwen_i) & in_service;

    // An SC that already went out is committed; only a fresh SC in IDLE can fail.
    assign sc_fail = sc_fail_raw & (state_q == IDLE);

    assign dmemREN   = memop & memren_i;
    assign dmemWEN   = memop & memwen_i & ~sc_fail;
    assign dmemaddr  = addr_i;
    assign dmemstore = store_i;

    assign req     = dmemREN | dmemWEN;
    assign miss    = req & ~dhit;
    assign halt_go = valid_i & halt_i & ~req & in_service;

    assign stall_o       = miss | halted_o;
    assign memwb_flush_o = miss;
    assign memwb_en_o    = ~miss;
    assign halted_o      = (state_q == HALT);
    assign err_o         = err_q;

    assign rdata_o = (valid_i & sc_i) ? {{31{1'b0}}, ~sc_fail} : dmemload;

    assign wait_cnt_inc = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;

    ll_sc_link u_link (
        .CLK           (CLK),
        .nRST          (nRST),
        .sc_i          (valid_i & sc_i),
        .addr_i        (addr_i),
        .ll_hit_i      (dmemREN & ll_i & dhit),
        .st_hit_i      (dmemWEN & dhit),
        .ccinv_i       (ccinv),
        .ccsnoopaddr_i (ccsnoopaddr),
        .sc_fail_o     (sc_fail_raw)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (miss) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= '0;
                    end else if (halt_go) begin
                        state_q <= HALT;
                    end
                end
                WAIT: begin
                    if (dhit) begin
                        state_q <= IDLE;
                    end else if (halt_go) begin
                        state_q <= HALT;
                    end else begin
                        wait_cnt_q <= wait_cnt_inc;
                        if (TIMEOUT_EN && (wait_cnt_inc == CNT_MAX)) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: an abstract model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_access_ctrl;
    import cpu_types_pkg::*;

    localparam int T = 8;

    logic  CLK, nRST;
    logic  valid_i, memren_i, memwen_i, ll_i, sc_i, halt_i;
    word_t addr_i, store_i;
    logic  dhit;
    word_t dmemload;
    logic  ccinv;
    word_t ccsnoopaddr;
    logic  dmemREN, dmemWEN;
    word_t dmemaddr, dmemstore, rdata_o;
    logic  stall_o, memwb_en_o, memwb_flush_o, halted_o, err_o;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_ctrl #(.TIMEOUT(T)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .valid_i       (valid_i),
        .memren_i      (memren_i),
        .memwen_i      (memwen_i),
        .ll_i          (ll_i),
        .sc_i          (sc_i),
        .halt_i        (halt_i),
        .addr_i        (addr_i),
        .store_i       (store_i),
        .dhit          (dhit),
        .dmemload      (dmemload),
        .ccinv         (ccinv),
        .ccsnoopaddr   (ccsnoopaddr),
        .dmemREN       (dmemREN),
        .dmemWEN       (dmemWEN),
        .dmemaddr      (dmemaddr),
        .dmemstore     (dmemstore),
        .rdata_o       (rdata_o),
        .stall_o       (stall_o),
        .memwb_en_o    (memwb_en_o),
        .memwb_flush_o (memwb_flush_o),
        .halted_o      (halted_o),
        .err_o         (err_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Abstract model: link, halt, error and a run length of consecutive missed cycles.
    logic  m_link_v, m_halted, m_err;
    word_t m_link_a;
    int    m_misses;
    logic  e_live, e_scf, e_ren, e_wen, e_miss;

    always_comb begin
        e_live = nRST & ~m_halted;
        e_scf  = sc_i & (m_misses == 0) &
                 (~m_link_v | (m_link_a != addr_i) | (ccinv & (ccsnoopaddr == addr_i)));
        e_ren  = e_live & valid_i & memren_i;
        e_wen  = e_live & valid_i & memwen_i & ~e_scf;
        e_miss = (e_ren | e_wen) & ~dhit;
    end

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_link_v <= 1'b0;
            m_link_a <= '0;
            m_halted <= 1'b0;
            m_err    <= 1'b0;
            m_misses <= 0;
        end else begin
            if (e_ren && ll_i && dhit) begin
                m_link_a <= addr_i;
                m_link_v <= !(ccinv && ccsnoopaddr == addr_i);
            end else if ((e_wen && dhit) || (ccinv && ccsnoopaddr == m_link_a)) begin
                m_link_v <= 1'b0;
            end
            m_misses <= e_miss ? m_misses + 1 : 0;
            if (e_miss && (m_misses + 1 > T)) m_err <= 1'b1;
            if (e_live && valid_i && halt_i && !(e_ren || e_wen)) m_halted <= 1'b1;
        end
    end

    always @(negedge CLK) begin
        check_b("REN",   dmemREN,       e_ren);
        check_b("WEN",   dmemWEN,       e_wen);
        check_b("stall", stall_o,       e_miss | (nRST & m_halted));
        check_b("flush", memwb_flush_o, e_miss);
        check_b("en",    memwb_en_o,    ~e_miss);
        check_b("halted", halted_o,     m_halted);
        check_b("err",   err_o,         m_err);
        if (e_ren | e_wen) begin
            check("addr",  dmemaddr,  addr_i);
            check("store", dmemstore, store_i);
        end
        if (e_live && valid_i && ((memren_i && dhit) || sc_i))
            check("rdata", rdata_o, sc_i ? {31'b0, ~e_scf} : dmemload);
    end

    task automatic drive(input logic v, ren, wen, ll, sc, hlt, input word_t a, st,
                         input logic dh, input word_t ld, input logic inv, input word_t sn);
        @(posedge CLK);
        #1;
        valid_i = v; memren_i = ren; memwen_i = wen; ll_i = ll; sc_i = sc; halt_i = hlt;
        addr_i = a; store_i = st; dhit = dh; dmemload = ld; ccinv = inv; ccsnoopaddr = sn;
        @(negedge CLK);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0;
        valid_i = 1; memren_i = 1; memwen_i = 0; ll_i = 0; sc_i = 0; halt_i = 0;
        addr_i = 32'h40; store_i = 0; dhit = 0; dmemload = 0; ccinv = 0; ccsnoopaddr = 0;

        // Reset: a live load on the inputs must not produce a request.
        @(negedge CLK);
        check_b("rst_REN",   dmemREN, 1'b0);
        check_b("rst_stall", stall_o, 1'b0);
        check_b("rst_en",    memwb_en_o, 1'b1);
        check_b("rst_flush", memwb_flush_o, 1'b0);
        check_b("rst_halt",  halted_o, 1'b0);
        check_b("rst_err",   err_o, 1'b0);
        valid_i = 0; memren_i = 0;
        #2 nRST = 1'b1;

        // LW hit in the request cycle.
        drive(1, 1, 0, 0, 0, 0, 32'h40, 32'h0, 1, 32'hDEADBEEF, 0, 32'h0);
        check("lw_rdata", rdata_o, 32'hDEADBEEF);
        check_b("lw_REN", dmemREN, 1'b1);
        check_b("lw_stall", stall_o, 1'b0);

        // SW with three miss cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 0, 0, 0, 32'h80, 32'h1234, 0, 32'h0, 0, 32'h0);
            check_b("sw_stall", stall_o, 1'b1);
            check_b("sw_flush", memwb_flush_o, 1'b1);
            check_b("sw_WEN", dmemWEN, 1'b1);
            check_b("sw_en", memwb_en_o, 1'b0);
        end
        drive(1, 0, 1, 0, 0, 0, 32'h80, 32'h1234, 1, 32'h0, 0, 32'h0);
        check_b("sw_en4", memwb_en_o, 1'b1);
        check_b("sw_stall4", stall_o, 1'b0);

        // LL then SC succeeds; a repeated SC fails without stalling.
        drive(1, 1, 0, 1, 0, 0, 32'h100, 32'h0, 1, 32'h77, 0, 32'h0);
        idle();
        drive(1, 0, 1, 0, 1, 0, 32'h100, 32'h5, 1, 32'h0, 0, 32'h0);
        check_b("sc1_WEN", dmemWEN, 1'b1);
        check("sc1_rdata", rdata_o, 32'h1);
        check("sc1_store", dmemstore, 32'h5);
        drive(1, 0, 1, 0, 1, 0, 32'h100, 32'h5, 0, 32'h0, 0, 32'h0);
        check_b("sc2_WEN", dmemWEN, 1'b0);
        check("sc2_rdata", rdata_o, 32'h0);
        check_b("sc2_stall", stall_o, 1'b0);

        // Snoop invalidate of the linked word kills the SC.
        drive(1, 1, 0, 1, 0, 0, 32'h100, 32'h0, 1, 32'h0, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h100);
        drive(1, 0, 1, 0, 1, 0, 32'h100, 32'h5, 0, 32'h0, 0, 32'h0);
        check_b("inv_WEN", dmemWEN, 1'b0);
        check("inv_rdata", rdata_o, 32'h0);
        check_b("inv_stall", stall_o, 1'b0);

        // Snoop to an unrelated word leaves the link intact.
        drive(1, 1, 0, 1, 0, 0, 32'h300, 32'h0, 1, 32'h0, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h304);
        drive(1, 0, 1, 0, 1, 0, 32'h300, 32'h9, 1, 32'h0, 0, 32'h0);
        check_b("other_WEN", dmemWEN, 1'b1);
        check("other_rdata", rdata_o, 32'h1);

        // SC already issued stays committed across a later invalidate.
        drive(1, 1, 0, 1, 0, 0, 32'h100, 32'h0, 1, 32'h0, 0, 32'h0);
        drive(1, 0, 1, 0, 1, 0, 32'h100, 32'h6, 0, 32'h0, 0, 32'h0);
        check_b("scw_stall", stall_o, 1'b1);
        drive(1, 0, 1, 0, 1, 0, 32'h100, 32'h6, 0, 32'h0, 1, 32'h100);
        check_b("scw_WEN_inv", dmemWEN, 1'b1);
        drive(1, 0, 1, 0, 1, 0, 32'h100, 32'h6, 1, 32'h0, 0, 32'h0);
        check_b("scw_WEN", dmemWEN, 1'b1);
        check("scw_rdata", rdata_o, 32'h1);

        // LL hit with a same-cycle matching invalidate leaves no link.
        drive(1, 1, 0, 1, 0, 0, 32'h200, 32'h0, 1, 32'h0, 1, 32'h200);
        drive(1, 0, 1, 0, 1, 0, 32'h200, 32'h5, 1, 32'h0, 0, 32'h0);
        check_b("llinv_WEN", dmemWEN, 1'b0);
        check("llinv_rdata", rdata_o, 32'h0);

        // Non-memory instruction passes dmemload through.
        drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0000CAFE, 0, 32'h0);
        check_b("nop_REN", dmemREN, 1'b0);
        check_b("nop_en", memwb_en_o, 1'b1);
        check("nop_rdata", rdata_o, 32'h0000CAFE);

        // Halt behind a missing LW.
        drive(1, 1, 0, 0, 0, 0, 32'h44, 32'h0, 0, 32'h0, 0, 32'h0);
        drive(1, 1, 0, 0, 0, 0, 32'h44, 32'h0, 0, 32'h0, 0, 32'h0);
        drive(1, 1, 0, 0, 0, 0, 32'h44, 32'h0, 1, 32'h11, 0, 32'h0);
        check("halt_lw_rdata", rdata_o, 32'h11);
        drive(1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        check_b("halt_pre", halted_o, 1'b0);
        check_b("halt_pre_en", memwb_en_o, 1'b1);
        drive(1, 1, 0, 0, 0, 0, 32'h48, 32'h0, 0, 32'h0, 0, 32'h0);
        check_b("halt_post", halted_o, 1'b1);
        check_b("halt_REN", dmemREN, 1'b0);
        check_b("halt_stall", stall_o, 1'b1);
        check_b("halt_en", memwb_en_o, 1'b1);
        idle();
        #2 nRST = 1'b0;
        #1 check_b("halt_rst", halted_o, 1'b0);
        @(negedge CLK);
        #2 nRST = 1'b1;

        // Load that never hits: err after T waiting cycles, then async reset mid-wait.
        drive(1, 1, 0, 0, 0, 0, 32'h500, 32'h0, 0, 32'h0, 0, 32'h0);
        for (int i = 1; i <= T; i++) drive(1, 1, 0, 0, 0, 0, 32'h500, 32'h0, 0, 32'h0, 0, 32'h0);
        check_b("to_err_before", err_o, 1'b0);
        drive(1, 1, 0, 0, 0, 0, 32'h500, 32'h0, 0, 32'h0, 0, 32'h0);
        check_b("to_err_after", err_o, 1'b1);
        #2 nRST = 1'b0;
        #1;
        check_b("arst_REN", dmemREN, 1'b0);
        check_b("arst_stall", stall_o, 1'b0);
        check_b("arst_en", memwb_en_o, 1'b1);
        check_b("arst_err", err_o, 1'b0);
        @(negedge CLK);
        valid_i = 0; memren_i = 0;
        #2 nRST = 1'b1;
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
